// File: rtl/execute_muldiv.sv
// Execute stage: operand muxes, single-cycle ALU and an iterative RV32M multiply/divide unit,
// with valid/ready handshakes towards decode and the mem-stage output slot.
module execute_muldiv #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned MUL_CYCLES   = 2,
    parameter int unsigned A_SEL_WIDTH  = 3,
    parameter int unsigned B_SEL_WIDTH  = 3,
    parameter int unsigned ALU_OP_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    input  logic [XLEN-1:0]         pc_exe,
    input  logic [XLEN-1:0]         rs1_exe,
    input  logic [XLEN-1:0]         rs2_exe,
    input  logic [XLEN-1:0]         imm_exe,
    input  logic [XLEN-1:0]         instr_exe,
    input  logic [XLEN-1:0]         forward_alu,
    input  logic [XLEN-1:0]         forward_mem,
    input  logic [A_SEL_WIDTH-1:0]  a_sel,
    input  logic [B_SEL_WIDTH-1:0]  b_sel,
    input  logic [ALU_OP_WIDTH-1:0] alu_op,
    input  logic                    md_en,
    input  logic [2:0]              md_op,
    output logic [XLEN-1:0]         alu_exe,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         pc_mem,
    output logic [XLEN-1:0]         alu_mem,
    output logic [XLEN-1:0]         rs2_mem,
    output logic [XLEN-1:0]         instr_mem,
    output logic                    busy
);

    localparam int unsigned CW = $clog2(XLEN + 1);
    localparam int unsigned SW = $clog2(XLEN);

    localparam logic [A_SEL_WIDTH-1:0] ASelRs1 = A_SEL_WIDTH'(0);
    localparam logic [A_SEL_WIDTH-1:0] ASelPc  = A_SEL_WIDTH'(1);
    localparam logic [A_SEL_WIDTH-1:0] ASelAlu = A_SEL_WIDTH'(2);
    localparam logic [A_SEL_WIDTH-1:0] ASelMem = A_SEL_WIDTH'(3);

    localparam logic [B_SEL_WIDTH-1:0] BSelRs2  = B_SEL_WIDTH'(0);
    localparam logic [B_SEL_WIDTH-1:0] BSelImm  = B_SEL_WIDTH'(1);
    localparam logic [B_SEL_WIDTH-1:0] BSelFour = B_SEL_WIDTH'(2);
    localparam logic [B_SEL_WIDTH-1:0] BSelAlu  = B_SEL_WIDTH'(3);
    localparam logic [B_SEL_WIDTH-1:0] BSelMem  = B_SEL_WIDTH'(4);

    localparam logic [ALU_OP_WIDTH-1:0] AluAdd  = ALU_OP_WIDTH'(0);
    localparam logic [ALU_OP_WIDTH-1:0] AluSub  = ALU_OP_WIDTH'(1);
    localparam logic [ALU_OP_WIDTH-1:0] AluSll  = ALU_OP_WIDTH'(2);
    localparam logic [ALU_OP_WIDTH-1:0] AluSlt  = ALU_OP_WIDTH'(3);
    localparam logic [ALU_OP_WIDTH-1:0] AluSltu = ALU_OP_WIDTH'(4);
    localparam logic [ALU_OP_WIDTH-1:0] AluXor  = ALU_OP_WIDTH'(5);
    localparam logic [ALU_OP_WIDTH-1:0] AluSrl  = ALU_OP_WIDTH'(6);
    localparam logic [ALU_OP_WIDTH-1:0] AluSra  = ALU_OP_WIDTH'(7);
    localparam logic [ALU_OP_WIDTH-1:0] AluOr   = ALU_OP_WIDTH'(8);
    localparam logic [ALU_OP_WIDTH-1:0] AluAnd  = ALU_OP_WIDTH'(9);

    typedef enum logic [1:0] {StIdle, StHold, StDiv, StDone} state_e;

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   res_q, pc_q, rs2_q, instr_q;
    logic [XLEN-1:0]   quo_q, rem_q, dvs_q;
    logic              qneg_q, rneg_q, is_rem_q;

    logic [XLEN-1:0]   alu_a, alu_b, alu_result;
    logic [SW-1:0]     shamt;
    logic              slot_free, accept, finish, slot_load;
    logic [XLEN-1:0]   slot_res, slot_pc, slot_rs2, slot_instr;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state_q == StIdle) && slot_free;
    assign accept    = in_valid && in_ready && !flush;
    assign busy      = (state_q != StIdle);
    assign alu_exe   = alu_result;
    assign shamt     = alu_b[SW-1:0];

    always_comb begin
        alu_a = '0;
        case (a_sel)
            ASelRs1: alu_a = rs1_exe;
            ASelPc:  alu_a = pc_exe;
            ASelAlu: alu_a = forward_alu;
            ASelMem: alu_a = forward_mem;
            default: alu_a = '0;
        endcase
        alu_b = '0;
        case (b_sel)
            BSelRs2:  alu_b = rs2_exe;
            BSelImm:  alu_b = imm_exe;
            BSelFour: alu_b = XLEN'(4);
            BSelAlu:  alu_b = forward_alu;
            BSelMem:  alu_b = forward_mem;
            default:  alu_b = '0;
        endcase
    end

    always_comb begin
        alu_result = '0;
        case (alu_op)
            AluAdd:  alu_result = alu_a + alu_b;
            AluSub:  alu_result = alu_a - alu_b;
            AluSll:  alu_result = alu_a << shamt;
            AluSlt:  alu_result = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            AluSltu: alu_result = {{(XLEN-1){1'b0}}, alu_a < alu_b};
            AluXor:  alu_result = alu_a ^ alu_b;
            AluSrl:  alu_result = alu_a >> shamt;
            AluSra:  alu_result = $signed(alu_a) >>> shamt;
            AluOr:   alu_result = alu_a | alu_b;
            AluAnd:  alu_result = alu_a & alu_b;
            default: alu_result = '0;
        endcase
    end

    // Multiply: sign-extend to 2*XLEN so one unsigned '*' covers all signedness variants.
    logic              mul_a_signed, mul_b_signed;
    logic [2*XLEN-1:0] mul_a, mul_b, prod;
    logic [XLEN-1:0]   mul_res;

    always_comb begin
        mul_a_signed = (md_op[1:0] == 2'd1) || (md_op[1:0] == 2'd2);
        mul_b_signed = (md_op[1:0] == 2'd1);
        mul_a   = {{XLEN{mul_a_signed & alu_a[XLEN-1]}}, alu_a};
        mul_b   = {{XLEN{mul_b_signed & alu_b[XLEN-1]}}, alu_b};
        prod    = mul_a * mul_b;
        mul_res = (md_op[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    logic            div_signed, div_is_rem, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, div_special;
    logic [XLEN:0]   trial;
    logic            trial_ge;
    logic [XLEN-1:0] rem_next, quo_next, q_fix, r_fix, div_res;

    always_comb begin
        div_signed  = !md_op[0];
        div_is_rem  = md_op[1];
        a_neg       = div_signed & alu_a[XLEN-1];
        b_neg       = div_signed & alu_b[XLEN-1];
        a_mag       = a_neg ? -alu_a : alu_a;
        b_mag       = b_neg ? -alu_b : alu_b;
        div_zero    = (alu_b == '0);
        div_ovf     = div_signed && (alu_a == {1'b1, {(XLEN-1){1'b0}}}) && (alu_b == '1);
        div_special = div_zero ? (div_is_rem ? alu_a : '1) : (div_is_rem ? '0 : alu_a);
        // Restoring step: shift the next dividend bit into the partial remainder.
        trial       = {rem_q, quo_q[XLEN-1]};
        trial_ge    = (trial >= {1'b0, dvs_q});
        rem_next    = trial_ge ? (trial[XLEN-1:0] - dvs_q) : trial[XLEN-1:0];
        quo_next    = {quo_q[XLEN-2:0], trial_ge};
        q_fix       = qneg_q ? -quo_q : quo_q;
        r_fix       = rneg_q ? -rem_q : rem_q;
        div_res     = is_rem_q ? r_fix : q_fix;
    end

    always_comb begin
        slot_load  = 1'b0;
        finish     = 1'b0;
        slot_res   = res_q;
        slot_pc    = pc_q;
        slot_rs2   = rs2_q;
        slot_instr = instr_q;
        unique case (state_q)
            StIdle: if (accept && !md_en) begin
                slot_load  = 1'b1;
                slot_res   = alu_result;
                slot_pc    = pc_exe;
                slot_rs2   = rs2_exe;
                slot_instr = instr_exe;
            end
            StHold: finish = (cnt_q == '0);
            StDiv: begin
                finish   = (cnt_q == '0);
                slot_res = div_res;
            end
            StDone: finish = 1'b1;
            default: ;
        endcase
        if (finish && slot_free && !flush) slot_load = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            pc_mem    <= '0;
            alu_mem   <= '0;
            rs2_mem   <= '0;
            instr_mem <= '0;
        end else if (slot_load) begin
            out_valid <= 1'b1;
            pc_mem    <= slot_pc;
            alu_mem   <= slot_res;
            rs2_mem   <= slot_rs2;
            instr_mem <= slot_instr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            res_q    <= '0;
            pc_q     <= '0;
            rs2_q    <= '0;
            instr_q  <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            is_rem_q <= 1'b0;
        end else if (flush) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: if (accept && md_en) begin
                    pc_q    <= pc_exe;
                    rs2_q   <= rs2_exe;
                    instr_q <= instr_exe;
                    if (!md_op[2]) begin
                        res_q   <= mul_res;
                        cnt_q   <= CW'(MUL_CYCLES - 1);
                        state_q <= StHold;
                    end else if (div_zero || div_ovf) begin
                        res_q   <= div_special;
                        cnt_q   <= '0;
                        state_q <= StHold;
                    end else begin
                        quo_q    <= a_mag;
                        dvs_q    <= b_mag;
                        rem_q    <= '0;
                        qneg_q   <= a_neg ^ b_neg;
                        rneg_q   <= a_neg;
                        is_rem_q <= div_is_rem;
                        cnt_q    <= CW'(XLEN);
                        state_q  <= StDiv;
                    end
                end
                StHold: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                    else state_q <= slot_free ? StIdle : StDone;
                end
                StDiv: begin
                    if (cnt_q != '0) begin
                        quo_q <= quo_next;
                        rem_q <= rem_next;
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        res_q   <= div_res;
                        state_q <= slot_free ? StIdle : StDone;
                    end
                end
                StDone: if (slot_free) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_muldiv.sv
// Bench for execute_muldiv: directed vectors, expected results queued at issue and
// checked by an independent monitor whenever the mem stage consumes an output.
module tb_execute_muldiv;

    logic        clk, rst_n, in_valid, in_ready, flush, md_en, out_valid, out_ready, busy;
    logic [31:0] pc_exe, rs1_exe, rs2_exe, imm_exe, instr_exe, forward_alu, forward_mem;
    logic [31:0] alu_exe, pc_mem, alu_mem, rs2_mem, instr_mem;
    logic [2:0]  a_sel, b_sel, md_op;
    logic [3:0]  alu_op;

    typedef struct {logic [31:0] res; logic [31:0] pc;} exp_t;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    execute_muldiv #(.XLEN(32), .MUL_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .pc_exe(pc_exe), .rs1_exe(rs1_exe), .rs2_exe(rs2_exe), .imm_exe(imm_exe),
        .instr_exe(instr_exe), .forward_alu(forward_alu), .forward_mem(forward_mem),
        .a_sel(a_sel), .b_sel(b_sel), .alu_op(alu_op), .md_en(md_en), .md_op(md_op),
        .alu_exe(alu_exe), .out_valid(out_valid), .out_ready(out_ready), .pc_mem(pc_mem),
        .alu_mem(alu_mem), .rs2_mem(rs2_mem), .instr_mem(instr_mem), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Monitor: every consumed output must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got %h expected none", alu_mem);
            end else begin
                e = sb.pop_front();
                if (alu_mem !== e.res || pc_mem !== e.pc) begin
                    n_fail++;
                    $display("FAIL result pc=%h: got %h/pc %h expected %h/pc %h",
                             e.pc, alu_mem, pc_mem, e.res, e.pc);
                end
            end
        end
    end

    task automatic wait_ready(input string nm, output bit ok);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        ok = in_ready;
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_accept_timeout: got in_ready=0 expected 1", nm);
        end
    endtask

    // loads_at: edges after the accept edge at which the slot loads (0 = same edge).
    task automatic issue(input string nm, input logic md, input logic [2:0] op,
                         input logic [31:0] pc, input logic [31:0] expv, input int loads_at);
        int k = 0;
        int low = 0;
        bit ok;
        exp_t e;
        @(posedge clk); #1;
        pc_exe = pc; md_en = md; md_op = op; in_valid = 1'b1;
        instr_exe = instr_exe + 1;
        wait_ready(nm, ok);
        if (!ok) begin
            in_valid = 1'b0;
            return;
        end
        e.res = expv; e.pc = pc;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0; md_en = 1'b0;
        @(negedge clk);
        while (!out_valid && k < 100) begin
            if (!in_ready) low++;
            @(negedge clk);
            k++;
        end
        check({nm, "_latency"}, k, loads_at);
        if (md) check({nm, "_in_ready_low"}, low, loads_at);
        else    check({nm, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic alu_issue(input string nm, input logic [2:0] as, input logic [2:0] bs,
                             input logic [3:0] op, input logic [31:0] pc,
                             input logic [31:0] expv);
        a_sel = as; b_sel = bs; alu_op = op;
        issue(nm, 1'b0, 3'd0, pc, expv, 0);
    endtask

    task automatic md_issue(input string nm, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] expv, input int at);
        a_sel = 3'd0; b_sel = 3'd0; rs1_exe = a; rs2_exe = b;
        issue(nm, 1'b1, op, 32'h3000 + {29'd0, op}, expv, at);
    endtask

    initial begin
        bit ok;
        int hi;
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; md_en = 1'b0; md_op = 3'd0;
        out_ready = 1'b1; a_sel = 3'd0; b_sel = 3'd0; alu_op = 4'd0;
        pc_exe = 32'd0; rs1_exe = 32'd0; rs2_exe = 32'd0; imm_exe = 32'd0;
        instr_exe = 32'h100; forward_alu = 32'd0; forward_mem = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_alu_mem", alu_mem, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;

        // ALU path: operand mux coverage.
        forward_alu = 32'd5; imm_exe = 32'd7;
        alu_issue("add_fwd_imm", 3'd2, 3'd1, 4'd0, 32'h1000, 32'd12);
        rs1_exe = 32'd3; rs2_exe = 32'd5;
        alu_issue("sub_neg", 3'd0, 3'd0, 4'd1, 32'h1004, 32'hFFFF_FFFE);
        alu_issue("pc_plus4", 3'd1, 3'd2, 4'd0, 32'h2000, 32'h2004);
        forward_mem = 32'hCAFE_0000;
        alu_issue("zero_or_mem", 3'd4, 3'd4, 4'd8, 32'h1008, 32'hCAFE_0000);
        rs1_exe = 32'h8000_0000; imm_exe = 32'd4;
        alu_issue("sra", 3'd0, 3'd1, 4'd7, 32'h100C, 32'hF800_0000);
        rs1_exe = 32'd1; forward_alu = 32'hFFFF_FFFF;
        alu_issue("sltu", 3'd0, 3'd3, 4'd4, 32'h1010, 32'd1);
        alu_issue("slt", 3'd0, 3'd3, 4'd3, 32'h1014, 32'd0);
        imm_exe = 32'd9;
        alu_issue("bad_asel_zero", 3'd7, 3'd1, 4'd0, 32'h1018, 32'd9);

        // Multiply.
        md_issue("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
        md_issue("mul", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 2);
        md_issue("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 2);
        md_issue("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);

        // Divide, iterative and special cases.
        md_issue("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        md_issue("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        md_issue("divu", 3'd5, 32'd100, 32'd7, 32'd14, 33);
        md_issue("remu", 3'd7, 32'd100, 32'd7, 32'd2, 33);
        md_issue("rem_negdvs", 3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        md_issue("divu_zero", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        md_issue("remu_zero", 3'd7, 32'd5, 32'd0, 32'd5, 1);
        md_issue("rem_zero_s", 3'd6, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);
        md_issue("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        md_issue("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // Back-to-back ALU ops, one per cycle.
        @(posedge clk); #1;
        a_sel = 3'd0; b_sel = 3'd0; alu_op = 4'd0; rs2_exe = 32'd100; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            rs1_exe = 32'(i * 3 + 1);
            pc_exe = 32'h4000 + 32'(i * 4);
            e.res = rs1_exe + 32'd100; e.pc = pc_exe;
            sb.push_back(e);
            @(negedge clk);
            check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);

        // Backpressure: full slot blocks a DIV until the mem stage consumes.
        out_ready = 1'b0;
        rs1_exe = 32'h11; rs2_exe = 32'h22;
        alu_issue("bp_add", 3'd0, 3'd0, 4'd0, 32'h4100, 32'h33);
        fork
            md_issue("bp_div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
                    check("bp_alu_mem_held", alu_mem, 32'h33);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join

        // Flush mid-DIV: result discarded, next op accepted.
        @(posedge clk); #1;
        a_sel = 3'd0; b_sel = 3'd0; rs1_exe = 32'd100; rs2_exe = 32'd3;
        md_en = 1'b1; md_op = 3'd4; pc_exe = 32'h4200; in_valid = 1'b1;
        wait_ready("flush_div", ok);
        @(posedge clk); #1;
        in_valid = 1'b0; md_en = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy", {31'd0, busy}, 32'd0);
        hi = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) hi++;
        end
        check("flush_no_result", hi, 0);
        rs1_exe = 32'd20; rs2_exe = 32'd22;
        alu_issue("post_flush_add", 3'd0, 3'd0, 4'd0, 32'h4300, 32'd42);

        // Reset mid-MUL clears the slot and aborts the op.
        rs1_exe = 32'h40; rs2_exe = 32'd2;
        alu_issue("pre_rst_add", 3'd0, 3'd0, 4'd0, 32'h5000, 32'h42);
        @(negedge clk);
        check("pre_rst_alu_mem", alu_mem, 32'h42);
        check("pre_rst_pc_mem", pc_mem, 32'h5000);
        @(posedge clk); #1;
        rs1_exe = 32'd6; rs2_exe = 32'd7; md_en = 1'b1; md_op = 3'd0; in_valid = 1'b1;
        wait_ready("rst_mul", ok);
        @(posedge clk); #1;
        in_valid = 1'b0; md_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_alu_mem", alu_mem, 32'd0);
        check("rst_mid_pc_mem", pc_mem, 32'd0);
        check("rst_mid_instr_mem", instr_mem, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hi = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) hi++;
        end
        check("rst_no_result", hi, 0);
        md_issue("post_rst_mul", 3'd0, 32'd6, 32'd7, 32'd42, 2);

        repeat (3) @(posedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
